// File: rtl/if_pc_unit_pkg.sv
// Shared constants and FSM encodings for the instruction-fetch PC unit.
package if_pc_unit_pkg;

   localparam logic [31:0] PC_STEP    = 32'd4;
   localparam logic [31:0] RET_OFFSET = 32'd8;
   localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

   typedef enum logic [1:0] {
      st_fill = 2'd0,
      st_run  = 2'd1,
      st_hold = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/ifid_pipe_reg.sv
// IF/ID pipeline register: instruction, its address and the jal/jalr return address.
module ifid_pipe_reg
   import if_pc_unit_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [31:0] instr_in,
   input  logic [31:0] pc_in,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic [31:0] pc8,
   output logic        valid
);

   always_ff @(posedge clk) begin
      if (reset) begin
         instr <= NOP_INSTR;
         pc    <= 32'h0;
         pc8   <= 32'h0;
         valid <= 1'b0;
      end else if (en) begin
         instr <= instr_in;
         pc    <= pc_in;
         pc8   <= pc_in + RET_OFFSET;
         valid <= 1'b1;
      end
   end

endmodule

// File: rtl/if_pc_unit.sv
// Fetch-stage PC/nPC pair with one branch delay slot, stall-safe redirect capture
// and the IF/ID register.
module if_pc_unit
   import if_pc_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] target,
   input  logic [31:0] instr_in,
   output logic [31:0] pc_out,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_pc,
   output logic [31:0] ifid_pc8,
   output logic        ifid_valid,
   output logic [1:0]  state
);

   fetch_state_e state_q;
   logic [31:0]  pc_q, npc_q, pend_target_q;
   logic         pend_valid_q;
   logic         advance, take;
   logic [31:0]  eff_target;

   // FILL always advances and never redirects; otherwise stall freezes the pipe.
   assign advance    = (state_q == st_fill) || !stall;
   assign take       = (state_q != st_fill) && (redirect || pend_valid_q);
   assign eff_target = (redirect ? target : pend_target_q) & ~32'd3;

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q          <= RESET_PC;
         npc_q         <= RESET_PC + PC_STEP;
         pend_target_q <= 32'h0;
         pend_valid_q  <= 1'b0;
         state_q       <= st_fill;
      end else begin
         if (advance) begin
            pc_q         <= npc_q;
            npc_q        <= take ? eff_target : npc_q + PC_STEP;
            pend_valid_q <= 1'b0;
         end else if (redirect) begin
            // Remember the redirect across the stall; the latest one wins.
            pend_target_q <= target;
            pend_valid_q  <= 1'b1;
         end

         unique case (state_q)
            st_fill: state_q <= st_run;
            st_run:  state_q <= stall ? st_hold : st_run;
            st_hold: state_q <= stall ? st_hold : st_run;
            default: state_q <= st_fill;
         endcase
      end
   end

   assign pc_out = pc_q;
   assign state  = state_q;

   ifid_pipe_reg u_ifid (
      .clk      (clk),
      .reset    (reset),
      .en       (advance),
      .instr_in (instr_in),
      .pc_in    (pc_q),
      .instr    (ifid_instr),
      .pc       (ifid_pc),
      .pc8      (ifid_pc8),
      .valid    (ifid_valid)
   );

endmodule

// File: tb/tb_if_pc_unit.sv
// Directed self-checking bench for if_pc_unit.
module tb_if_pc_unit;

   localparam logic [31:0] IMASK = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        reset, stall, redirect;
   logic [31:0] target;
   logic [31:0] instr_in;
   logic [31:0] pc_out, ifid_instr, ifid_pc, ifid_pc8;
   logic        ifid_valid;
   logic [1:0]  state;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // Instruction memory stand-in: the word is a fixed function of its address.
   assign instr_in = pc_out ^ IMASK;

   if_pc_unit dut (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .redirect   (redirect),
      .target     (target),
      .instr_in   (instr_in),
      .pc_out     (pc_out),
      .ifid_instr (ifid_instr),
      .ifid_pc    (ifid_pc),
      .ifid_pc8   (ifid_pc8),
      .ifid_valid (ifid_valid),
      .state      (state)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Check the full IF/ID contents for a fetched instruction at address a.
   task automatic check_ifid(input string tag, input logic [31:0] a);
      check({tag, ".ifid_pc"}, ifid_pc, a);
      check({tag, ".ifid_pc8"}, ifid_pc8, a + 32'd8);
      check({tag, ".ifid_instr"}, ifid_instr, a ^ IMASK);
      check({tag, ".ifid_valid"}, {31'b0, ifid_valid}, 32'd1);
   endtask

   // Reset and free-run until pc_out = 0x10.
   task automatic run_to_10();
      reset = 1'b1; stall = 1'b0; redirect = 1'b0; target = 32'h0;
      step();
      reset = 1'b0;
      repeat (4) step();
      check("run_to_10.pc", pc_out, 32'h10);
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; redirect = 1'b0; target = 32'h0;
      step();
      // Reset state
      check("rst.pc", pc_out, 32'h0);
      check("rst.state", {30'b0, state}, 32'd0);
      check("rst.valid", {31'b0, ifid_valid}, 32'd0);
      check("rst.ifid_pc", ifid_pc, 32'h0);
      check("rst.ifid_pc8", ifid_pc8, 32'h0);
      check("rst.ifid_instr", ifid_instr, 32'h0);

      // Free run with the FILL cycle
      reset = 1'b0;
      step();
      check("fill.pc", pc_out, 32'h4);
      check("fill.state", {30'b0, state}, 32'd1);
      check_ifid("fill", 32'h0);
      step();
      check("run.pc8", pc_out, 32'h8);
      check_ifid("run4", 32'h4);

      // Redirect at PC=0x08: delay slot 0x0C, then 0x100, 0x104
      redirect = 1'b1; target = 32'h100;
      step();
      redirect = 1'b0;
      check("br.slot", pc_out, 32'hC);
      check_ifid("br8", 32'h8);
      step();
      check("br.tgt", pc_out, 32'h100);
      step();
      check("br.next", pc_out, 32'h104);
      check_ifid("br100", 32'h100);

      // Plain 3-cycle stall at 0x10
      run_to_10();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall.pc", pc_out, 32'h10);
         check("stall.state", {30'b0, state}, 32'd2);
         check_ifid("stall", 32'hC);
      end
      stall = 1'b0;
      step();
      check("rel.pc", pc_out, 32'h14);
      check("rel.state", {30'b0, state}, 32'd1);
      check_ifid("rel", 32'h10);

      // Redirect to 0x200 during stall is kept
      run_to_10();
      stall = 1'b1; redirect = 1'b1; target = 32'h200;
      step();
      redirect = 1'b0;
      step();
      check("pend.hold", pc_out, 32'h10);
      stall = 1'b0;
      step();
      check("pend.slot", pc_out, 32'h14);
      step();
      check("pend.tgt", pc_out, 32'h200);
      step();
      check("pend.next", pc_out, 32'h204);

      // Two redirects in HOLD: last wins
      run_to_10();
      stall = 1'b1; redirect = 1'b1; target = 32'h200;
      step();
      target = 32'h300;
      step();
      redirect = 1'b0; stall = 1'b0;
      step();
      check("ovr.slot", pc_out, 32'h14);
      step();
      check("ovr.tgt", pc_out, 32'h300);

      // New redirect on release cycle beats the pending one
      run_to_10();
      stall = 1'b1; redirect = 1'b1; target = 32'h200;
      step();
      stall = 1'b0; target = 32'h400;
      step();
      redirect = 1'b0;
      check("pri.slot", pc_out, 32'h14);
      step();
      check("pri.tgt", pc_out, 32'h400);

      // Misaligned target drops low bits
      run_to_10();
      redirect = 1'b1; target = 32'h203;
      step();
      redirect = 1'b0;
      check("mis.slot", pc_out, 32'h14);
      step();
      check("mis.tgt", pc_out, 32'h200);

      // Wrap-around at the top of the address space
      redirect = 1'b1; target = 32'hFFFF_FFF8;
      step();
      redirect = 1'b0;
      check("wrap.slot", pc_out, 32'h204);
      step();
      check("wrap.f8", pc_out, 32'hFFFF_FFF8);
      step();
      check("wrap.fc", pc_out, 32'hFFFF_FFFC);
      check("wrap.pc8", ifid_pc8, 32'h0);
      step();
      check("wrap.zero", pc_out, 32'h0);
      check("wrap.pc8b", ifid_pc8, 32'h4);

      // Reset mid-HOLD with a pending redirect discards it
      run_to_10();
      stall = 1'b1; redirect = 1'b1; target = 32'h200;
      step();
      reset = 1'b1;
      step();
      check("mrst.pc", pc_out, 32'h0);
      check("mrst.valid", {31'b0, ifid_valid}, 32'd0);
      check("mrst.state", {30'b0, state}, 32'd0);
      // FILL ignores stall and redirect
      reset = 1'b0; target = 32'h300;
      step();
      redirect = 1'b0;
      check("mrst.fill", pc_out, 32'h4);
      check("mrst.fstate", {30'b0, state}, 32'd1);
      step();
      check("mrst.hold", pc_out, 32'h4);
      check("mrst.hstate", {30'b0, state}, 32'd2);
      stall = 1'b0;
      step();
      check("mrst.rel", pc_out, 32'h8);
      step();
      check("mrst.seq", pc_out, 32'hC);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
